inbuf_rd_ctrl: RTL

- Read-side sequencer for the input buffer of the EC accelerator.
- Drains one stripe of SRAM-FIFO words, one beat at a time, into the input buffer's output register array, then presents each beat to the BM multiplier units.
- Holds each beat until the multipliers consume it.
- Generates the fifo read request, memory enable and output-register load strobe; reports busy, done and sticky error.

---
 rtl/inbuf_pkg.sv | 17 +
 rtl/inbuf_rd_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/inbuf_pkg.sv
// Shared definitions for the input-buffer read sequencer: FSM state encoding and
// the supported range of the SRAM fifo read latency.
package inbuf_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int RD_LAT_MAX = 4;
  localparam int LAT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/inbuf_rd_ctrl.sv
// Read-side sequencer for the EC accelerator input buffer: fetches one fifo word
// per beat, loads it into the output register and holds it until consumed.
module inbuf_rd_ctrl
  import inbuf_pkg::*;
#(
  parameter int BEATS_W = 8,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [BEATS_W-1:0] stripe_beats,
  input  logic               inbuf_fifo_cntl_empty,
  input  logic               inbuf_rd_data_val,
  input  logic               bm_cntl_consume,
  output logic               cntl_inbuf_fifo_rd_rq,
  output logic               cntl_inbuf_fifo_mem_en,
  output logic               cntrl_inbuff_rd_en,
  output logic               cntl_bm_beat_val,
  output logic [BEATS_W-1:0] cntl_beat_idx,
  output logic               cntl_busy,
  output logic               cntl_done,
  output logic               cntl_err
);

  state_e             state_q, state_d;
  logic [BEATS_W-1:0] cnt_q, cnt_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic [LAT_W-1:0]   lat_q, lat_d, lat_dec;
  logic               err_q, err_d;

  assign lat_dec = lat_q - LAT_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    lat_d   = lat_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          beats_d = stripe_beats;
          cnt_d   = '0;
          state_d = (stripe_beats == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!inbuf_fifo_cntl_empty) begin
          lat_d   = LAT_W'(RD_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        lat_d = lat_dec;
        // Data must land exactly on the last latency cycle; early or missing is fatal.
        if (lat_dec == '0) begin
          if (inbuf_rd_data_val) begin
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (inbuf_rd_data_val) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_LOAD: state_d = S_HOLD;
      S_HOLD: begin
        if (bm_cntl_consume) begin
          if (cnt_q == beats_q - BEATS_W'(1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + BEATS_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_d   = err_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beats_q <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  assign cntl_inbuf_fifo_rd_rq  = (state_q == S_FETCH) && !inbuf_fifo_cntl_empty;
  assign cntl_inbuf_fifo_mem_en = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                                  (state_q == S_LOAD);
  assign cntrl_inbuff_rd_en     = (state_q == S_LOAD);
  assign cntl_bm_beat_val       = (state_q == S_HOLD);
  assign cntl_beat_idx          = cnt_q;
  assign cntl_busy              = (state_q != S_IDLE);
  assign cntl_done              = (state_q == S_DONE);
  assign cntl_err               = err_q;

endmodule
